// File: rtl/reaction_pkg.sv
// -----------------------------------------------------------------------------
// reaction_pkg
// Shared types and defaults for the reaction-time game controller.
//   state_t         : FSM state encoding, also exported on state_o
//   time_ms_t       : 14-bit millisecond quantity (reaction and delay times)
//   DEF_*           : default parameter values for reaction_game_ctrl
//   lfsr_feedback() : feedback bit of the 16-bit Fibonacci LFSR (taps 16,14,13,11)
// -----------------------------------------------------------------------------
package reaction_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_WAIT_RAND = 3'd2,
        ST_GO        = 3'd3,
        ST_RESULT    = 3'd4,
        ST_FOUL      = 3'd5
    } state_t;

    typedef logic [13:0] time_ms_t;

    localparam int          DEF_MIN_DELAY_MS = 1000;
    localparam int          DEF_TIMEOUT_MS   = 9999;
    localparam logic [15:0] DEF_LFSR_SEED    = 16'hACE1;

    // Taps 16,14,13,11 map to bits 15,13,12,10 of a left-shifting register.
    function automatic logic lfsr_feedback(input logic [15:0] q);
        return q[15] ^ q[13] ^ q[12] ^ q[10];
    endfunction

endpackage

// File: rtl/reaction_lfsr.sv
// -----------------------------------------------------------------------------
// reaction_lfsr
// Free-running 16-bit Fibonacci LFSR used to randomise the pre-GO delay.
// It steps on every clock, independent of the game state.
// Ports:
//   clk   in  1   system clock
//   rst_n in  1   asynchronous active-low reset, loads seed
//   seed  in  16  reset value, must be nonzero
//   q     out 16  current LFSR state
// -----------------------------------------------------------------------------
module reaction_lfsr
    import reaction_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= seed;
        end else begin
            q <= {q[14:0], lfsr_feedback(q)};
        end
    end

endmodule

// File: rtl/reaction_game_ctrl.sv
// -----------------------------------------------------------------------------
// reaction_game_ctrl
// Sequencing FSM of a reaction-time game: start -> external countdown ->
// random wait -> GO lamp -> measure time to the reaction button press.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | after reset, waiting for btn_start
// COUNTDOWN  | external countdown running, waiting for countdown_done
// WAIT_RAND  | random delay (MIN_DELAY_MS + lfsr[10:0] ms) counting down
// GO         | go_led lit, counting ms until btn_react or timeout
// RESULT     | reaction_ms holds the measured time, result_valid high
// FOUL       | react pressed before GO, false_start high
//
// Parameters:
//   MIN_DELAY_MS  minimum random wait in ms
//   TIMEOUT_MS    reaction time saturation value in ms
//   LFSR_SEED     nonzero LFSR reset value
// Ports:
//   clk                 in  1   system clock
//   rst_n               in  1   asynchronous active-low reset
//   tick_1ms            in  1   one-cycle enable once per ms
//   btn_start           in  1   debounced start pulse
//   btn_react           in  1   debounced reaction pulse
//   countdown_done      in  1   countdown finished (level)
//   countdown_in_action in  1   countdown running (level)
//   countdown_start     out 1   pulse launching the countdown
//   go_led              out 1   high while the player must react
//   reaction_ms         out 14  last measured reaction time
//   result_valid        out 1   high in RESULT
//   false_start         out 1   high in FOUL
//   best_ms             out 14  best valid reaction time
//   state_o             out 3   current state encoding
// Build option:
//   REACTION_BEST_EN    defined: best_ms tracks the lowest non-timeout result;
//                       undefined: best_ms is constant TIMEOUT_MS.
// -----------------------------------------------------------------------------
module reaction_game_ctrl
    import reaction_pkg::*;
#(
    parameter int          MIN_DELAY_MS = DEF_MIN_DELAY_MS,
    parameter int          TIMEOUT_MS   = DEF_TIMEOUT_MS,
    parameter logic [15:0] LFSR_SEED    = DEF_LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_1ms,
    input  logic        btn_start,
    input  logic        btn_react,
    input  logic        countdown_done,
    input  logic        countdown_in_action,
    output logic        countdown_start,
    output logic        go_led,
    output logic [13:0] reaction_ms,
    output logic        result_valid,
    output logic        false_start,
    output logic [13:0] best_ms,
    output logic [2:0]  state_o
);

    localparam time_ms_t TIMEOUT_T = time_ms_t'(TIMEOUT_MS);
    localparam time_ms_t MIN_T     = time_ms_t'(MIN_DELAY_MS);

    state_t      state;
    time_ms_t    delay_cnt;
    time_ms_t    go_cnt;
    time_ms_t    go_cnt_inc;
    time_ms_t    delay_load;
    logic [15:0] lfsr_q;
    logic        lfsr_unused;

    reaction_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    // Only the low 11 bits randomise the delay, giving 0..2047 ms extra.
    assign delay_load  = MIN_T + {3'b000, lfsr_q[10:0]};
    assign lfsr_unused = ^lfsr_q[15:11];
    assign go_cnt_inc  = go_cnt + 14'd1;
    assign state_o     = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            countdown_start <= 1'b0;
            go_led          <= 1'b0;
            reaction_ms     <= '0;
            result_valid    <= 1'b0;
            false_start     <= 1'b0;
            delay_cnt       <= '0;
            go_cnt          <= '0;
        end else begin
            countdown_start <= 1'b0;
            case (state)
                ST_IDLE, ST_RESULT, ST_FOUL: begin
                    // Start has priority; a simultaneous react is dropped.
                    if (btn_start) begin
                        state           <= ST_COUNTDOWN;
                        countdown_start <= 1'b1;
                        result_valid    <= 1'b0;
                        false_start     <= 1'b0;
                    end
                end

                ST_COUNTDOWN: begin
                    if (btn_react) begin
                        state       <= ST_FOUL;
                        false_start <= 1'b1;
                    end else if (countdown_done && !countdown_in_action) begin
                        state     <= ST_WAIT_RAND;
                        delay_cnt <= delay_load;
                    end
                end

                ST_WAIT_RAND: begin
                    if (btn_react) begin
                        state       <= ST_FOUL;
                        false_start <= 1'b1;
                    end else if (tick_1ms) begin
                        // GO is entered on the tick that brings the delay to 0.
                        if (delay_cnt <= 14'd1) begin
                            delay_cnt <= '0;
                            go_cnt    <= '0;
                            go_led    <= 1'b1;
                            state     <= ST_GO;
                        end else begin
                            delay_cnt <= delay_cnt - 14'd1;
                        end
                    end
                end

                ST_GO: begin
                    // A press on a tick edge reports the pre-increment count.
                    if (btn_react) begin
                        reaction_ms  <= go_cnt;
                        result_valid <= 1'b1;
                        go_led       <= 1'b0;
                        state        <= ST_RESULT;
                    end else if (tick_1ms) begin
                        if (go_cnt_inc >= TIMEOUT_T) begin
                            go_cnt       <= TIMEOUT_T;
                            reaction_ms  <= TIMEOUT_T;
                            result_valid <= 1'b1;
                            go_led       <= 1'b0;
                            state        <= ST_RESULT;
                        end else begin
                            go_cnt <= go_cnt_inc;
                        end
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    go_led <= 1'b0;
                end
            endcase
        end
    end

`ifdef REACTION_BEST_EN
    time_ms_t best_q;

    // Only a real press can improve the record; the timeout path never does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_q <= TIMEOUT_T;
        end else if (state == ST_GO && btn_react && go_cnt < best_q) begin
            best_q <= go_cnt;
        end
    end

    assign best_ms = best_q;
`else
    assign best_ms = TIMEOUT_T;
`endif

endmodule

// File: doc/reaction_game_ctrl.md
REACTION_GAME_CTRL -- requirements
Module: reaction_game_ctrl

Interface
REQ-001 SHALL have parameter MIN_DELAY_MS, default 1000, minimum random wait in ms.
REQ-002 SHALL have parameter TIMEOUT_MS, default 9999, reaction-time saturation value in ms.
REQ-003 SHALL have parameter LFSR_SEED, default 16'hACE1, nonzero LFSR reset value.
REQ-004 clk  in  1  system clock; the only clock.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 tick_1ms  in  1  one-cycle enable, once per ms.
REQ-007 btn_start  in  1  debounced one-cycle start pulse.
REQ-008 btn_react  in  1  debounced one-cycle reaction pulse.
REQ-009 countdown_done  in  1  countdown finished, level.
REQ-010 countdown_in_action  in  1  countdown running, level.
REQ-011 countdown_start  out  1  one-cycle pulse that launches the countdown.
REQ-012 go_led  out  1  high while the player must react.
REQ-013 reaction_ms  out  14  last measured reaction time.
REQ-014 result_valid  out  1  high while the state is RESULT.
REQ-015 false_start  out  1  high while the state is FOUL.
REQ-016 best_ms  out  14  best (lowest) valid reaction time.
REQ-017 state_o  out  3  current FSM state encoding.

Function
REQ-018 FSM states SHALL be IDLE, COUNTDOWN, WAIT_RAND, GO, RESULT and FOUL, all registered; there SHALL be no combinational path from input to output.
REQ-019 In IDLE, RESULT or FOUL: btn_start -> COUNTDOWN next edge; countdown_start pulses exactly that cycle; result_valid and false_start clear.
REQ-020 In COUNTDOWN: countdown_done=1 with countdown_in_action=0 -> WAIT_RAND; delay counter loads MIN_DELAY_MS + lfsr[10:0], giving a range of 1000..3047.
REQ-021 In WAIT_RAND: the delay decrements on each tick_1ms; reaching 0 -> GO on the next edge; go_led rises with GO.
REQ-022 In COUNTDOWN or WAIT_RAND: btn_react -> FOUL; false_start=1; reaction_ms is unchanged.
REQ-023 In GO: the counter clears on entry and increments per tick_1ms; btn_react -> RESULT with reaction_ms = counter value on that edge.
REQ-024 Counter reaching TIMEOUT_MS in GO -> RESULT with reaction_ms=TIMEOUT_MS; the counter SHALL never exceed TIMEOUT_MS.
REQ-025 Simultaneous tick_1ms and btn_react in GO: the press wins; the pre-increment value is reported.
REQ-026 Simultaneous btn_start and btn_react in IDLE/RESULT/FOUL: start wins and react is ignored.
REQ-027 btn_start in COUNTDOWN, WAIT_RAND or GO SHALL be ignored.
REQ-028 The 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every clk regardless of state.

Reset
REQ-029 rst_n low -> state IDLE, countdown_start=0, go_led=0, reaction_ms=0, result_valid=0, false_start=0, best_ms=TIMEOUT_MS, LFSR=LFSR_SEED, counters=0.
REQ-030 Reset asserted mid-game SHALL abort the game immediately with no countdown_start pulse on release.

Configuration
REQ-031 Macro REACTION_BEST_EN defined: on RESULT entry, best_ms updates when reaction_ms < best_ms and no timeout occurred; FOUL never updates it.
REQ-032 Macro REACTION_BEST_EN undefined: best_ms is tied to TIMEOUT_MS, no best register exists, and the port is still present.

Structure
REQ-033 Package reaction_pkg SHALL hold the state enum, the 14-bit time typedef and the default constants (1000, 9999, 16'hACE1).
REQ-034 The LFSR SHALL be the sub-module reaction_lfsr (clk, rst_n, seed, q[15:0]).

Verification
REQ-035 btn_start from IDLE -> countdown_start high for exactly 1 cycle; state COUNTDOWN.
REQ-036 Force lfsr[10:0]=0, countdown_done -> exactly 1000 ticks until go_led=1.
REQ-037 In GO: 237 ticks, then btn_react -> reaction_ms=237, result_valid=1, best_ms=237 (macro on).
REQ-038 btn_react during WAIT_RAND -> false_start=1, go_led stays 0, best_ms unchanged.
REQ-039 No press in GO -> after 9999 ticks reaction_ms=9999 and best_ms is not updated.
REQ-040 rst_n low in GO at count 500 -> all outputs at reset values; after release the FSM waits in IDLE.
